// File: rtl/context_save_restore.sv
// Context-switch bus master: copies a register-bank range to data
// memory (SAVE) or reloads it from memory into the bank (RESTORE).
module context_save_restore #(
    parameter int FIRST_REG = 1,
    parameter int LAST_REG  = 26,
    parameter int RD_LAT    = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    input  logic [31:0] base_addr,
    output logic        busy,
    output logic        done,
    output logic [4:0]  rf_read_addr,
    input  logic [31:0] rf_read_data,
    output logic [4:0]  rf_write_reg,
    output logic [31:0] rf_write_data,
    output logic        rf_write_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_req,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    typedef enum logic [2:0] {
        IDLE, SV_RD, SV_WAIT, SV_MEM, RS_MEM, RS_WR, DONE
    } state_t;

    localparam logic [4:0] FIRST = 5'(FIRST_REG);
    localparam logic [4:0] LAST  = 5'(LAST_REG);

    state_t      r_state;
    logic [4:0]  r_idx;
    logic [31:0] r_base;
    logic [7:0]  r_lat;
    logic        r_busy;
    logic        r_done;
    logic [4:0]  r_rd_addr;
    logic [4:0]  r_wr_reg;
    logic [31:0] r_wr_data;
    logic        r_wr_en;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_mem_req;
    logic        r_mem_we;

    logic [4:0]  w_idx_nxt;
    logic [31:0] w_addr_cur;
    logic [31:0] w_addr_nxt;
    logic        w_last;

    // Slot offset is relative to FIRST_REG; the 32-bit sum wraps freely
    assign w_idx_nxt  = r_idx + 5'd1;
    assign w_addr_cur = r_base + {27'd0, r_idx - FIRST};
    assign w_addr_nxt = r_base + {27'd0, w_idx_nxt - FIRST};
    assign w_last     = (r_idx == LAST);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_idx       <= FIRST;
            r_base      <= '0;
            r_lat       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_addr   <= '0;
            r_wr_reg    <= '0;
            r_wr_data   <= '0;
            r_wr_en     <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_base <= base_addr;
                        r_idx  <= FIRST;
                        r_busy <= 1'b1;
                        if (!mode) begin
                            r_rd_addr <= FIRST;
                            r_state   <= SV_RD;
                        end else begin
                            r_mem_addr <= base_addr;
                            r_mem_req  <= 1'b1;
                            r_mem_we   <= 1'b0;
                            r_state    <= RS_MEM;
                        end
                    end
                end
                SV_RD: begin
                    r_lat   <= 8'd1;
                    r_state <= SV_WAIT;
                end
                SV_WAIT: begin
                    if (r_lat >= 8'(RD_LAT)) begin
                        r_mem_wdata <= rf_read_data;
                        r_mem_addr  <= w_addr_cur;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_state     <= SV_MEM;
                    end else begin
                        r_lat <= r_lat + 8'd1;
                    end
                end
                SV_MEM: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= DONE;
                        end else begin
                            r_idx     <= w_idx_nxt;
                            r_rd_addr <= w_idx_nxt;
                            r_state   <= SV_RD;
                        end
                    end
                end
                RS_MEM: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_wr_data <= mem_rdata;
                        r_wr_reg  <= r_idx;
                        r_wr_en   <= 1'b1;
                        r_state   <= RS_WR;
                    end
                end
                RS_WR: begin
                    r_wr_en <= 1'b0;
                    if (w_last) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= DONE;
                    end else begin
                        r_idx      <= w_idx_nxt;
                        r_mem_addr <= w_addr_nxt;
                        r_mem_req  <= 1'b1;
                        r_state    <= RS_MEM;
                    end
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign rf_read_addr  = r_rd_addr;
    assign rf_write_reg  = r_wr_reg;
    assign rf_write_data = r_wr_data;
    assign rf_write_en   = r_wr_en;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign mem_req       = r_mem_req;
    assign mem_we        = r_mem_we;
endmodule
